// File: rtl/el2_lsu_trigger_sched.sv
// LSU data-trigger CSR storage and hit sequencing: detect, hold until commit/flush, report with valid/ack.
// Optional feature macro: RV_LSU_TRIGGER_CHAIN_EN (pairs triggers 0/1 and 2/3 through the chain bit).

package el2_lsu_trigger_sched_pkg;
  typedef struct packed {
    logic        select;
    logic        match;
    logic        store;
    logic        load;
    logic        m;
    logic [31:0] tdata2;
  } trigger_pkt_t;
endpackage

module el2_lsu_trigger_sched
  import el2_lsu_trigger_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   csr_wr_en,
  input  logic [1:0]             csr_wr_idx,
  input  logic                   csr_wr_sel,
  input  logic [31:0]            csr_wr_data,
  input  logic                   dbg_mode,
  output trigger_pkt_t [3:0]     trigger_pkt_any,
  output logic [3:0][31:0]       tdata1_rd,
  input  logic [3:0]             lsu_trigger_match_m,
  input  logic                   lsu_pkt_m_valid,
  input  logic                   lsu_commit_r,
  input  logic                   lsu_flush_r,
  output logic                   trig_hit_valid,
  output logic [3:0]             trig_hit_vec,
  output logic                   trig_hit_action,
  input  logic                   trig_hit_ack,
  output logic [7:0]             trig_drop_cnt
);

  localparam int unsigned NTRIG    = 4;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned CNTW     = 8;
  localparam int unsigned B_LOAD   = 0;
  localparam int unsigned B_STORE  = 1;
  localparam int unsigned B_M      = 6;
  localparam int unsigned B_MATCH  = 7;
  localparam int unsigned B_ACTION = 12;
  localparam int unsigned B_SELECT = 19;
  localparam int unsigned B_HIT    = 20;
  localparam int unsigned B_DMODE  = 27;
`ifdef RV_LSU_TRIGGER_CHAIN_EN
  localparam int unsigned B_CHAIN  = 11;
  localparam logic [XLEN-1:0] T1_MASK = 32'h0818_18C3;
`else
  localparam logic [XLEN-1:0] T1_MASK = 32'h0818_10C3;
`endif

  typedef enum logic [1:0] {IDLE, PEND, REPORT} state_t;

  state_t                      state, state_nxt;
  logic [NTRIG-1:0][XLEN-1:0]  tdata1, tdata1_nxt;
  logic [NTRIG-1:0][XLEN-1:0]  tdata2, tdata2_nxt;
  logic [XLEN-1:0]             wr_t1;
  logic [NTRIG-1:0]            q_raw, q, act_bits;
  logic [NTRIG-1:0]            hit_r, hit_nxt;
  logic                        action_r, action_nxt;
  logic                        drop_inc;

  // Qualify raw matches and apply pairwise chaining.
  always_comb begin
    q_raw = lsu_trigger_match_m & {NTRIG{lsu_pkt_m_valid}};
    q     = q_raw;
`ifdef RV_LSU_TRIGGER_CHAIN_EN
    if (tdata1[0][B_CHAIN]) begin
      q[0] = q_raw[0] & q_raw[1];
      q[1] = q_raw[1] & q_raw[0];
    end
    if (tdata1[2][B_CHAIN]) begin
      q[2] = q_raw[2] & q_raw[3];
      q[3] = q_raw[3] & q_raw[2];
    end
`endif
    for (int i = 0; i < NTRIG; i++) act_bits[i] = tdata1[i][B_ACTION];
  end

  // CSR writes; a dmode-owned trigger is locked outside debug mode.
  always_comb begin
    tdata1_nxt = tdata1;
    tdata2_nxt = tdata2;
    wr_t1      = '0;
    if (csr_wr_en && !(tdata1[csr_wr_idx][B_DMODE] && !dbg_mode)) begin
      if (!csr_wr_sel) begin
        wr_t1         = csr_wr_data & T1_MASK;
        wr_t1[B_HIT]  = csr_wr_data[B_HIT] & tdata1[csr_wr_idx][B_HIT];
        if (!dbg_mode) wr_t1[B_DMODE] = 1'b0;
        tdata1_nxt[csr_wr_idx] = wr_t1;
      end else begin
        tdata2_nxt[csr_wr_idx] = csr_wr_data;
      end
    end
    if (state == REPORT && trig_hit_ack) begin
      for (int i = 0; i < NTRIG; i++)
        if (hit_r[i]) tdata1_nxt[i][B_HIT] = 1'b1;
    end
  end

  // Hit sequencing next-state.
  always_comb begin
    state_nxt  = state;
    hit_nxt    = hit_r;
    action_nxt = action_r;
    drop_inc   = (state != IDLE) && (|q) && (trig_drop_cnt != {CNTW{1'b1}});
    case (state)
      IDLE: begin
        if (|q) begin
          hit_nxt    = q;
          action_nxt = |(q & act_bits);
          state_nxt  = PEND;
        end
      end
      PEND: begin
        if (lsu_flush_r) begin
          hit_nxt    = '0;
          action_nxt = 1'b0;
          state_nxt  = IDLE;
        end else if (lsu_commit_r) begin
          state_nxt  = REPORT;
        end
      end
      REPORT: begin
        if (trig_hit_ack) begin
          hit_nxt    = '0;
          action_nxt = 1'b0;
          state_nxt  = IDLE;
        end
      end
      default: begin
        hit_nxt    = '0;
        action_nxt = 1'b0;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state           <= IDLE;
      tdata1          <= '0;
      tdata2          <= '0;
      hit_r           <= '0;
      action_r        <= 1'b0;
      trig_hit_valid  <= 1'b0;
      trig_hit_vec    <= '0;
      trig_hit_action <= 1'b0;
      trig_drop_cnt   <= '0;
    end else begin
      state           <= state_nxt;
      tdata1          <= tdata1_nxt;
      tdata2          <= tdata2_nxt;
      hit_r           <= hit_nxt;
      action_r        <= action_nxt;
      trig_hit_valid  <= (state_nxt == REPORT);
      trig_hit_vec    <= (state_nxt == REPORT) ? hit_nxt : '0;
      trig_hit_action <= (state_nxt == REPORT) ? action_nxt : 1'b0;
      if (drop_inc) trig_drop_cnt <= trig_drop_cnt + CNTW'(1);
    end
  end

  // Matcher packets and readback come straight from the CSR registers.
  always_comb begin
    for (int i = 0; i < NTRIG; i++) begin
      trigger_pkt_any[i].select = tdata1[i][B_SELECT];
      trigger_pkt_any[i].match  = tdata1[i][B_MATCH];
      trigger_pkt_any[i].store  = tdata1[i][B_STORE];
      trigger_pkt_any[i].load   = tdata1[i][B_LOAD];
      trigger_pkt_any[i].m      = tdata1[i][B_M];
      trigger_pkt_any[i].tdata2 = tdata2[i];
    end
  end

  assign tdata1_rd = tdata1;

endmodule

// File: tb/tb_el2_lsu_trigger_sched.sv
// Directed self-checking bench for el2_lsu_trigger_sched (works with or without RV_LSU_TRIGGER_CHAIN_EN).
module tb_el2_lsu_trigger_sched;
  import el2_lsu_trigger_sched_pkg::*;

  logic               clk;
  logic               rst_l;
  logic               csr_wr_en;
  logic [1:0]         csr_wr_idx;
  logic               csr_wr_sel;
  logic [31:0]        csr_wr_data;
  logic               dbg_mode;
  trigger_pkt_t [3:0] trigger_pkt_any;
  logic [3:0][31:0]   tdata1_rd;
  logic [3:0]         lsu_trigger_match_m;
  logic               lsu_pkt_m_valid;
  logic               lsu_commit_r;
  logic               lsu_flush_r;
  logic               trig_hit_valid;
  logic [3:0]         trig_hit_vec;
  logic               trig_hit_action;
  logic               trig_hit_ack;
  logic [7:0]         trig_drop_cnt;

  int checks = 0;
  int errors = 0;

  el2_lsu_trigger_sched dut (
    .clk                 (clk),
    .rst_l               (rst_l),
    .csr_wr_en           (csr_wr_en),
    .csr_wr_idx          (csr_wr_idx),
    .csr_wr_sel          (csr_wr_sel),
    .csr_wr_data         (csr_wr_data),
    .dbg_mode            (dbg_mode),
    .trigger_pkt_any     (trigger_pkt_any),
    .tdata1_rd           (tdata1_rd),
    .lsu_trigger_match_m (lsu_trigger_match_m),
    .lsu_pkt_m_valid     (lsu_pkt_m_valid),
    .lsu_commit_r        (lsu_commit_r),
    .lsu_flush_r         (lsu_flush_r),
    .trig_hit_valid      (trig_hit_valid),
    .trig_hit_vec        (trig_hit_vec),
    .trig_hit_action     (trig_hit_action),
    .trig_hit_ack        (trig_hit_ack),
    .trig_drop_cnt       (trig_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [1:0] idx, input logic sel, input logic [31:0] data);
    csr_wr_en   = 1'b1;
    csr_wr_idx  = idx;
    csr_wr_sel  = sel;
    csr_wr_data = data;
    tick();
    csr_wr_en   = 1'b0;
  endtask

  task automatic match_once(input logic [3:0] m);
    lsu_trigger_match_m = m;
    lsu_pkt_m_valid     = 1'b1;
    tick();
    lsu_trigger_match_m = 4'b0;
    lsu_pkt_m_valid     = 1'b0;
  endtask

  task automatic commit_once();
    lsu_commit_r = 1'b1;
    tick();
    lsu_commit_r = 1'b0;
  endtask

  task automatic ack_once();
    trig_hit_ack = 1'b1;
    tick();
    trig_hit_ack = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0; csr_wr_en = 1'b0; csr_wr_idx = 2'd0; csr_wr_sel = 1'b0; csr_wr_data = '0;
    dbg_mode = 1'b0; lsu_trigger_match_m = '0; lsu_pkt_m_valid = 1'b0;
    lsu_commit_r = 1'b0; lsu_flush_r = 1'b0; trig_hit_ack = 1'b0;
    #12;
    chk("rst_valid", 32'(trig_hit_valid), 32'd0);
    chk("rst_vec", 32'(trig_hit_vec), 32'd0);
    chk("rst_action", 32'(trig_hit_action), 32'd0);
    chk("rst_drop", 32'(trig_drop_cnt), 32'd0);
    chk("rst_pkt_zero", 32'(trigger_pkt_any == '0), 32'd1);
    rst_l = 1'b1;
    tick();

    // Basic load/store trigger on 0, commit one cycle after match
    csr_write(2'd0, 1'b1, 32'h0000_1000);
    csr_write(2'd0, 1'b0, 32'h0000_0043);
    chk("t1_rd0", tdata1_rd[0], 32'h0000_0043);
    chk("pkt0_tdata2", trigger_pkt_any[0].tdata2, 32'h0000_1000);
    chk("pkt0_flags", 32'({trigger_pkt_any[0].select, trigger_pkt_any[0].match, trigger_pkt_any[0].store,
                           trigger_pkt_any[0].load, trigger_pkt_any[0].m}), 32'b00111);
    match_once(4'b0001);
    chk("pend_no_valid", 32'(trig_hit_valid), 32'd0);
    commit_once();
    chk("rep_valid", 32'(trig_hit_valid), 32'd1);
    chk("rep_vec", 32'(trig_hit_vec), 32'h1);
    chk("rep_action", 32'(trig_hit_action), 32'd0);
    chk("hit_before_ack", 32'(tdata1_rd[0][20]), 32'd0);
    ack_once();
    chk("ack_valid_low", 32'(trig_hit_valid), 32'd0);
    chk("sticky_hit0", tdata1_rd[0], 32'h0010_0043);

    // Flush and commit together: flush wins
    match_once(4'b0010);
    lsu_flush_r = 1'b1; lsu_commit_r = 1'b1;
    tick();
    lsu_flush_r = 1'b0; lsu_commit_r = 1'b0;
    chk("flush_valid", 32'(trig_hit_valid), 32'd0);
    tick();
    chk("flush_valid_later", 32'(trig_hit_valid), 32'd0);
    chk("flush_hit1", tdata1_rd[1], 32'h0);
    chk("flush_hit0", tdata1_rd[0], 32'h0010_0043);
    chk("flush_drop", 32'(trig_drop_cnt), 32'd0);

    // Ack without valid is ignored; action bit propagates
    ack_once();
    chk("stray_ack", 32'(trig_hit_valid), 32'd0);
    csr_write(2'd2, 1'b0, 32'h0000_1043);
    match_once(4'b0100);
    commit_once();
    chk("act_vec", 32'(trig_hit_vec), 32'h4);
    chk("act_action", 32'(trig_hit_action), 32'd1);
    ack_once();
    chk("act_sticky2", tdata1_rd[2], 32'h0010_1043);

    // Chain on trigger 0 (also clears sticky hit 0)
    csr_write(2'd0, 1'b0, 32'h0000_0843);
`ifdef RV_LSU_TRIGGER_CHAIN_EN
    chk("chain_rd", tdata1_rd[0], 32'h0000_0843);
    match_once(4'b0001);
    commit_once();
    chk("chain_single_nohit", 32'(trig_hit_valid), 32'd0);
    match_once(4'b0011);
    commit_once();
    chk("chain_pair_valid", 32'(trig_hit_valid), 32'd1);
    chk("chain_pair_vec", 32'(trig_hit_vec), 32'h3);
    ack_once();
`else
    chk("chain_rd", tdata1_rd[0], 32'h0000_0043);
    match_once(4'b0001);
    commit_once();
    chk("nochain_valid", 32'(trig_hit_valid), 32'd1);
    chk("nochain_vec", 32'(trig_hit_vec), 32'h1);
    ack_once();
`endif

    // dmode lock
    dbg_mode = 1'b1;
    csr_write(2'd2, 1'b0, 32'h0800_0043);
    chk("dmode_set", tdata1_rd[2], 32'h0800_0043);
    dbg_mode = 1'b0;
    csr_write(2'd2, 1'b1, 32'h0000_FFFF);
    chk("dmode_lock_t2", trigger_pkt_any[2].tdata2, 32'h0);
    csr_write(2'd2, 1'b0, 32'h0000_0000);
    chk("dmode_lock_t1", tdata1_rd[2], 32'h0800_0043);
    dbg_mode = 1'b1;
    csr_write(2'd2, 1'b1, 32'h0000_FFFF);
    chk("dmode_unlock_t2", trigger_pkt_any[2].tdata2, 32'h0000_FFFF);
    dbg_mode = 1'b0;
    csr_write(2'd3, 1'b0, 32'h0800_0043);
    chk("dmode_strip", tdata1_rd[3], 32'h0000_0043);

    // Drop counter saturation while REPORT is held
    csr_write(2'd0, 1'b0, 32'h0000_0043);
    lsu_trigger_match_m = 4'b0001; lsu_pkt_m_valid = 1'b1;
    tick();
    chk("drop_idle_none", 32'(trig_drop_cnt), 32'd0);
    lsu_commit_r = 1'b1;
    tick();
    lsu_commit_r = 1'b0;
    chk("drop_first", 32'(trig_drop_cnt), 32'd1);
    lsu_trigger_match_m = 4'b0010;
    for (int i = 0; i < 300; i++) tick();
    lsu_trigger_match_m = 4'b0; lsu_pkt_m_valid = 1'b0;
    chk("drop_sat", 32'(trig_drop_cnt), 32'd255);
    chk("hold_valid", 32'(trig_hit_valid), 32'd1);
    chk("hold_vec", 32'(trig_hit_vec), 32'h1);

    // Asynchronous reset during REPORT
    rst_l = 1'b0;
    #1;
    chk("arst_valid", 32'(trig_hit_valid), 32'd0);
    chk("arst_vec", 32'(trig_hit_vec), 32'd0);
    chk("arst_drop", 32'(trig_drop_cnt), 32'd0);
    chk("arst_t1_2", tdata1_rd[2], 32'h0);
    chk("arst_pkt_zero", 32'(trigger_pkt_any == '0), 32'd1);
    #3;
    rst_l = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 32'(trig_hit_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/el2_lsu_trigger_sched.md
# el2_lsu_trigger_sched

Owns the four LSU data-trigger configurations and sequences trigger hits from detection to reporting. It drives the per-trigger packets consumed by the LSU trigger matcher and applies trigger chaining to the M-stage match vector. It holds a detected hit until the triggering instruction commits or flushes, then presents the hit to the decode/debug unit over a valid/ack handshake.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_l  in  1  reset, asynchronous, active-low
- csr_wr_en  in  1  trigger CSR write strobe
- csr_wr_idx  in  2  trigger index written
- csr_wr_sel  in  1  0 = tdata1, 1 = tdata2
- csr_wr_data  in  32  write data
- dbg_mode  in  1  core is in debug mode
- trigger_pkt_any  out  4x packet  per-trigger select, match, store, load, m, tdata2[31:0] to the matcher
- tdata1_rd  out  4x32  tdata1 readback
- lsu_trigger_match_m  in  4  raw match vector from the matcher
- lsu_pkt_m_valid  in  1  M-stage LSU op valid
- lsu_commit_r  in  1  pending instruction committed
- lsu_flush_r  in  1  pending instruction flushed
- trig_hit_valid  out  1  hit report valid
- trig_hit_vec  out  4  triggers that fired
- trig_hit_action  out  1  1 = enter debug mode, 0 = breakpoint exception
- trig_hit_ack  in  1  report accepted
- trig_drop_cnt  out  8  saturating count of hits dropped while busy

## Operation
- tdata1 fields: [0] load, [1] store, [6] m, [7] match, [11] chain, [12] action, [19] select, [20] hit (sticky), [27] dmode; all other bits read 0.
- Writes: a write to trigger i with dmode=1 is ignored unless dbg_mode=1. A write of dmode=1 outside debug mode stores dmode=0. Writing hit=0 clears the sticky hit bit.
- Qualified match q[i] = lsu_trigger_match_m[i] & lsu_pkt_m_valid, then chaining is applied, for pairs (0,1) and (2,3) when chain of the even trigger is 1:
  - q[even] = q[even] & q[odd]
  - q[odd] = q[odd] & q[even]
- States:
  - IDLE: if |q, capture q into hit_r, capture action = OR of action over hit triggers, and go to PEND.
  - PEND: if lsu_flush_r, discard and go to IDLE. Else if lsu_commit_r, go to REPORT. If both are asserted in the same cycle, flush wins.
  - REPORT: trig_hit_valid=1, trig_hit_vec=hit_r. On trig_hit_ack, set sticky hit for each set bit of hit_r and go to IDLE.
- Any |q while in PEND or REPORT increments trig_drop_cnt. The counter saturates at 255 and clears only on reset.
- A CSR write during PEND or REPORT takes effect normally; the captured hit_r and action are unchanged.

## Timing
- Reset values:
  - all tdata1/tdata2 = 0, so trigger_pkt_any is all 0
  - state IDLE
  - trig_hit_valid = 0, trig_hit_vec = 0, trig_hit_action = 0
  - trig_drop_cnt = 0
- trigger_pkt_any is registered: a CSR write at edge N drives the matcher from cycle N+1.
- A match sampled at edge N puts the block in PEND at N+1. The earliest trig_hit_valid is the cycle after the commit edge.
- trig_hit_valid and trig_hit_vec stay stable until ack. Ack sampled in the same cycle as the first valid cycle is legal, so REPORT can last 1 cycle.
- Ack with valid=0 is ignored.
- rst_l assertion mid-sequence returns to IDLE immediately and asynchronously, with no report.

## Configuration
- RV_LSU_TRIGGER_CHAIN_EN defined: chain bit is writable and chaining is applied as above.
- Undefined: chain bit is hardwired 0, reads 0, and each q[i] is used unpaired.

## Test plan
- Write tdata2[0]=0x1000 and tdata1[0]=0x43 (load, store, m). Drive match=0001 with valid, then commit one cycle later. Expect trig_hit_valid with vec=0001 and action=0. After ack, tdata1_rd[0][20]=1.
- Match=0010, then assert lsu_flush_r and lsu_commit_r in the same cycle. Expect return to IDLE, no valid, hit bits unchanged.
- Chain set on trigger 0 (macro on): match=0001 gives no hit; match=0011 gives vec=0011. With the macro off, match=0001 gives vec=0001.
- With dmode=1 on trigger 2 and dbg_mode=0, write tdata2=0xFFFF. Expect readback unchanged. With dbg_mode=1, the same write updates.
- Hold REPORT without ack while driving 300 matching cycles. Expect trig_drop_cnt=255 and vec unchanged.
- Assert rst_l low during REPORT. Expect valid=0 and all registers 0 asynchronously.
